ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter SYSTEM_FREQ, default 100000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter INHIBIT_US, default 120, meaning the time in microseconds that ps2_clk is held low before request-to-send.
REQ-003 The block SHALL have parameter TIMEOUT_MS, default 20, meaning the maximum time in milliseconds from the end of request-to-send until ack.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, used for all logic.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port tx_data, input, 8 bits: the command byte to send to the device.
REQ-007 The block SHALL have port tx_valid, input, 1 bit: a send request, accepted when tx_ready is 1.
REQ-008 The block SHALL have port tx_ready, output, 1 bit: 1 only in IDLE.
REQ-009 The block SHALL have port tx_done, output, 1 bit: a 1-cycle pulse on a successful, acknowledged send.
REQ-010 The block SHALL have port tx_error, output, 1 bit: a 1-cycle pulse on timeout or missing ack.
REQ-011 The block SHALL have port ps2_clk, inout, 1 bit: open-drain; the block drives 0 or high-Z only.
REQ-012 The block SHALL have port ps2_data, inout, 1 bit: open-drain; the block drives 0 or high-Z only.

Function
REQ-013 The block SHALL synchronise ps2_clk and ps2_data with 2 flops each, and SHALL detect ps2_clk falling edges on the synchronised value.
REQ-014 The FSM SHALL have the states IDLE, INHIBIT, RTS, SEND, WAIT_IDLE.
REQ-015 In IDLE with tx_valid=1, the block SHALL latch tx_data, compute odd parity (parity = ~^tx_data), clear bit_cnt and the timer, and go to INHIBIT.
REQ-016 In INHIBIT, the block SHALL drive ps2_clk=0 for INHIBIT_US*SYSTEM_FREQ/1e6 cycles, and SHALL drive ps2_data=0 during the last cycle.
REQ-017 On leaving INHIBIT for RTS, the block SHALL release ps2_clk and keep ps2_data=0 as the start bit.
REQ-018 In RTS and SEND, the timeout counter SHALL run; reaching TIMEOUT_MS*SYSTEM_FREQ/1000 cycles SHALL pulse tx_error, release both lines, and go to WAIT_IDLE.
REQ-019 RTS SHALL go to SEND on the first ps2_clk falling edge, driving data bit 0 on that edge.
REQ-020 In SEND, each falling edge SHALL increment bit_cnt (4 bits) and drive the next bit: bits 1-7 LSB first, then parity, then the stop bit (released).
REQ-021 A data value of 1 SHALL be driven as high-Z; only 0 SHALL be driven low.
REQ-022 On the 11th falling edge, the block SHALL sample ps2_data: 0 means ack OK (arm tx_done), 1 means tx_error; it SHALL then go to WAIT_IDLE.
REQ-023 WAIT_IDLE SHALL return to IDLE once the synchronised ps2_clk and ps2_data are both 1.
REQ-024 tx_done SHALL pulse in the same cycle as that transition and only if ack was OK.
REQ-025 tx_done and tx_error SHALL never both be asserted.
REQ-026 tx_valid outside IDLE SHALL be ignored, and the latched byte SHALL be unaffected.
REQ-027 A falling edge arriving during INHIBIT SHALL be ignored.

Reset
REQ-028 On reset=0, the block SHALL immediately release ps2_clk and ps2_data to high-Z, set the state to IDLE, set tx_ready=1, set tx_done=0 and tx_error=0, and clear all counters and synchronisers to 1.
REQ-029 A reset mid-transfer SHALL abort without any pulse, and the block SHALL accept a new request on the first cycle after reset deasserts.

Structure
REQ-030 Package ps2_pkg SHALL hold the FSM state enum, the bit-count constants (DATA_BITS=8, ACK_EDGE=11), and the cycle-count helper functions.
REQ-031 Sub-module ps2_sync_edge SHALL be used for each line: a 2-flop synchroniser with a falling-edge pulse output.

Verification
REQ-032 Send 0xED with a device model: the bench SHALL see ps2_clk low for at least 12000 cycles, then data 0,1,0,1,1,0,1,1,1, parity 1, stop 1; after the model acks, one tx_done pulse.
REQ-033 Send 0x01: the parity bit SHALL be 0. Send 0x00: the parity bit SHALL be 1.
REQ-034 With no device clocking: tx_error SHALL pulse exactly 2000000 cycles after RTS; lines released; tx_ready=1 afterwards.
REQ-035 The device model holds data high at the 11th edge: the block SHALL pulse tx_error, never tx_done.
REQ-036 Assert reset after the 5th falling edge: both lines SHALL be high-Z in the same cycle, with no pulses, and a following 0xF4 send SHALL complete normally.
REQ-037 Pulse tx_valid with 0x55 during SEND of 0xED: the transmitted byte SHALL remain 0xED, and exactly one tx_done pulse SHALL occur.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter.
//   - ps2_state_e    : transmit FSM states
//   - DATA_BITS      : payload bits per frame
//   - ACK_EDGE       : device clock falling edge on which the ack is sampled
//   - inhibit_cycles : clk cycles for a microsecond interval
//   - timeout_cycles : clk cycles for a millisecond interval
//   - odd_parity     : parity bit that makes the frame's one-count odd
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned ACK_EDGE  = 11;

    // The products overflow 32 bits at realistic clock rates, so use 64-bit math.
    function automatic int unsigned inhibit_cycles(input int unsigned freq_hz,
                                                   input int unsigned us);
        longint unsigned cyc;
        cyc = (64'(freq_hz) * 64'(us)) / 64'd1000000;
        return cyc[31:0];
    endfunction

    function automatic int unsigned timeout_cycles(input int unsigned freq_hz,
                                                   input int unsigned ms);
        longint unsigned cyc;
        cyc = (64'(freq_hz) * 64'(ms)) / 64'd1000;
        return cyc[31:0];
    endfunction

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchroniser for one PS/2 line plus a falling-edge
// detector on the synchronised value.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset (all flops reset to 1, idle bus)
//   line_i : asynchronous PS/2 line
//   sync_o : synchronised line level
//   fall_o : one-cycle pulse when sync_o goes 1 -> 0
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues request-to-send, shifts out 8 data bits, odd
// parity and stop on device clock falling edges, then checks the device ack.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   tx_data  : command byte, latched when accepted
//   tx_valid : send request, accepted while tx_ready is 1
//   tx_ready : 1 only while idle
//   tx_done  : one-cycle pulse after an acknowledged send
//   tx_error : one-cycle pulse on timeout or missing ack
//   ps2_clk  : open-drain PS/2 clock (driven 0 or released)
//   ps2_data : open-drain PS/2 data (driven 0 or released)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned SYSTEM_FREQ = 100000000,
    parameter int unsigned INHIBIT_US  = 120,
    parameter int unsigned TIMEOUT_MS  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    inout  wire        ps2_clk,
    inout  wire        ps2_data
);

    localparam int unsigned INHIBIT_CYC = inhibit_cycles(SYSTEM_FREQ, INHIBIT_US);
    localparam int unsigned TIMEOUT_CYC = timeout_cycles(SYSTEM_FREQ, TIMEOUT_MS);
    localparam int unsigned TMR_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] INH_DATA_AT = TMR_W'(INHIBIT_CYC - 2);
    localparam logic [TMR_W-1:0] INH_LAST    = TMR_W'(INHIBIT_CYC - 1);
    localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       BIT_PARITY  = 4'(DATA_BITS);
    localparam logic [3:0]       BIT_ACK     = 4'(ACK_EDGE - 1);

    ps2_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             ack_ok_q, ack_ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;
    logic next_bit;

    ps2_sync_edge u_clk_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .line_i (ps2_clk),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .line_i (ps2_data),
        .sync_o (data_sync),
        .fall_o (data_fall_unused)
    );

    // Bit to present after a SEND-state edge: remaining data bits, parity, then stop.
    always_comb begin
        if (bit_cnt_q < BIT_PARITY) begin
            next_bit = data_q[bit_cnt_q[2:0]];
        end else if (bit_cnt_q == BIT_PARITY) begin
            next_bit = parity_q;
        end else begin
            next_bit = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        parity_d  = parity_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    data_d    = tx_data;
                    parity_d  = odd_parity(tx_data);
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    ack_ok_d  = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Device edges here are our own clock pull-down; they are ignored.
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == INH_DATA_AT) begin
                    data_oe_d = 1'b1;
                end
                if (timer_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    timer_d  = '0;
                    state_d  = ST_RTS;
                end
            end
            ST_RTS, ST_SEND: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == TO_LAST) begin
                    err_d     = 1'b1;
                    ack_ok_d  = 1'b0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_WAIT_IDLE;
                end else if (clk_fall) begin
                    if (state_q == ST_RTS) begin
                        data_oe_d = ~data_q[0];
                        bit_cnt_d = 4'd1;
                        state_d   = ST_SEND;
                    end else if (bit_cnt_q == BIT_ACK) begin
                        data_oe_d = 1'b0;
                        if (!data_sync) begin
                            ack_ok_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        data_oe_d = ~next_bit;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d   = ack_ok_q;
                    ack_ok_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_done  = done_q;
    assign tx_error = err_q;
    assign ps2_clk  = clk_oe_q  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a PS/2 device model.
// The DUT runs at a scaled SYSTEM_FREQ so inhibit/timeout intervals stay short.
module tb_ps2_host_tx;

    localparam int unsigned SYS_FREQ = 10000000;
    localparam int unsigned INH_US   = 120;
    localparam int unsigned TO_MS    = 2;
    localparam int INH_CYC = int'((64'(INH_US) * 64'(SYS_FREQ)) / 64'd1000000);
    localparam int TO_CYC  = int'((64'(TO_MS) * 64'(SYS_FREQ)) / 64'd1000);
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    wire        ps2_clk;
    wire        ps2_data;
    logic       dev_clk_low;
    logic       dev_data_low;

    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
    pullup pu_clk  (ps2_clk);
    pullup pu_data (ps2_data);

    ps2_host_tx #(
        .SYSTEM_FREQ (SYS_FREQ),
        .INHIBIT_US  (INH_US),
        .TIMEOUT_MS  (TO_MS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [10:0] exp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt <= both_cnt + 1;
    end

    task automatic start_tx(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: tx_ready=%b required 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back({1'b1, ~^d, d, 1'b0});
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic dev_inhibit(output int low_len, output int t_rts, output logic start_bit);
        int n = 0;
        while (ps2_clk !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        low_len = 0;
        while (ps2_clk === 1'b0 && low_len < INH_CYC + 100) begin
            @(negedge clk);
            low_len++;
        end
        t_rts     = cyc;
        start_bit = ps2_data;
    endtask

    task automatic dev_frame(input int n_edges, input logic ack, input logic poke,
                             input logic start_bit, output logic [10:0] frame);
        frame    = '1;
        frame[0] = start_bit;
        for (int k = 1; k <= n_edges && k <= 10; k++) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            if (poke && k == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                checks++;
                if (tx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_send: tx_ready=%b required 0", tx_ready);
                end
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            frame[k]    = ps2_data;
            dev_clk_low = 1'b0;
        end
        if (n_edges >= 11) begin
            repeat (H) @(negedge clk);
            dev_data_low = ack;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL outcome_wait: no pulse after %0d cycles, required within 300", n);
        end
    endtask

    task automatic run_send(input logic [7:0] d, input logic ack, input logic poke,
                            output logic [10:0] frame);
        int d0, e0, len, t_rts;
        logic sb;
        logic [10:0] exp;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        dev_inhibit(len, t_rts, sb);
        checks++;
        if (len != INH_CYC) begin
            errors++;
            $display("FAIL inhibit_len: %0d cycles required %0d", len, INH_CYC);
        end
        dev_frame(11, ack, poke, sb, frame);
        exp = exp_q.pop_front();
        checks++;
        if (frame !== exp) begin
            errors++;
            $display("FAIL frame_%h: got %b required %b", d, frame, exp);
        end
        wait_outcome(d0, e0);
        checks++;
        if (done_cnt - d0 != (ack ? 1 : 0)) begin
            errors++;
            $display("FAIL done_count_%h: %0d required %0d", d, done_cnt - d0, ack ? 1 : 0);
        end
        checks++;
        if (err_cnt - e0 != (ack ? 0 : 1)) begin
            errors++;
            $display("FAIL error_count_%h: %0d required %0d", d, err_cnt - e0, ack ? 0 : 1);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_%h: %b required 1", d, tx_ready);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, tx_done, tx_error} !== 3'b100) begin
            errors++;
            $display("FAIL reset_outputs: ready/done/error=%b required 100",
                     {tx_ready, tx_done, tx_error});
        end
        checks++;
        if ({ps2_clk, ps2_data} !== 2'b11) begin
            errors++;
            $display("FAIL reset_lines: clk/data=%b required 11", {ps2_clk, ps2_data});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_send_ed();
        logic [10:0] f;
        run_send(8'hED, 1'b1, 1'b0, f);
        checks++;
        if (f !== 11'b11_11101101_0) begin
            errors++;
            $display("FAIL ed_literal: got %b required %b", f, 11'b11_11101101_0);
        end
    endtask

    task automatic test_parity();
        logic [10:0] f;
        run_send(8'h01, 1'b1, 1'b0, f);
        checks++;
        if (f[9] !== 1'b0) begin
            errors++;
            $display("FAIL parity_01: %b required 0", f[9]);
        end
        run_send(8'h00, 1'b1, 1'b0, f);
        checks++;
        if (f[9] !== 1'b1) begin
            errors++;
            $display("FAIL parity_00: %b required 1", f[9]);
        end
    endtask

    task automatic test_timeout();
        int d0, e0, len, t_rts, n;
        logic sb;
        logic [10:0] unused_exp;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA5);
        unused_exp = exp_q.pop_front();
        dev_inhibit(len, t_rts, sb);
        n = 0;
        while (tx_error !== 1'b1 && n < TO_CYC + 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc - t_rts != TO_CYC) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles required %0d", cyc - t_rts, TO_CYC);
        end
        checks++;
        if ({ps2_clk, ps2_data} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_lines: clk/data=%b required 11", {ps2_clk, ps2_data});
        end
        repeat (8) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready: %b required 1", tx_ready);
        end
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            errors++;
            $display("FAIL timeout_pulses: errors %0d dones %0d required 1 and 0",
                     err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_nack();
        logic [10:0] f;
        run_send(8'h3C, 1'b0, 1'b0, f);
    endtask

    task automatic test_reset_mid();
        int d0, e0, len, t_rts;
        logic sb;
        logic [10:0] f, exp;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h00);
        dev_inhibit(len, t_rts, sb);
        dev_frame(5, 1'b0, 1'b0, sb, f);
        exp = exp_q.pop_front();
        checks++;
        if (f[5:0] !== exp[5:0]) begin
            errors++;
            $display("FAIL partial_frame: got %b required %b", f[5:0], exp[5:0]);
        end
        checks++;
        if (ps2_data !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_data: %b required 0", ps2_data);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({ps2_clk, ps2_data} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: clk/data=%b required 11", {ps2_clk, ps2_data});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++;
            $display("FAIL reset_pulses: dones %0d errors %0d required 0 and 0",
                     done_cnt - d0, err_cnt - e0);
        end
        reset = 1'b1;
        start_tx(8'hF4);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_accept: tx_ready=%b required 0", tx_ready);
        end
        dev_inhibit(len, t_rts, sb);
        dev_frame(11, 1'b1, 1'b0, sb, f);
        exp = exp_q.pop_front();
        checks++;
        if (f !== exp) begin
            errors++;
            $display("FAIL frame_f4: got %b required %b", f, exp);
        end
        wait_outcome(d0, e0);
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL f4_pulses: dones %0d errors %0d required 1 and 0",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f;
        run_send(8'hED, 1'b1, 1'b1, f);
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_timeout();
        test_nack();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL exclusive_pulses: %0d cycles with both required 0", both_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
